pipe_skid_buffer: RTL and testbench
===================================

Name: pipe_skid_buffer

Overview:
- Consumer-side stage for the pipeline registers built from Register_n_bit-style load registers.
- The upstream register writes a word with a valid flag. This block holds that word and presents it downstream under a valid/ready handshake.
- A second (skid) entry absorbs one extra word when the consumer stalls, so in_ready is a pure register output with no combinational ready path back to the producer.
- Used between processor pipeline stages, for example IF/ID and ID/EX.

Parameters:
- n, 32, data word width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  n  word from producer
- in_valid  input  1  producer has a word this cycle
- in_ready  output  1  buffer accepts a word this cycle; driven directly from a flop
- out_data  output  n  word to consumer
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data this cycle
- occupancy  output  2  number of held words, 0..2

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Everything below happens on the rising edge of clk.
- Storage: main entry (main_data, main_valid) and skid entry (skid_data, skid_valid).
- Output mapping:
  - out_data = main_data, out_valid = main_valid.
  - in_ready = ~skid_valid & ~rst_q, where rst_q is a flop that is 1 during reset and clears on the first clock after rst deasserts.
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Reset: on the edge where rst=1, all data and valid flops go to 0 and occupancy goes to 0.
  - in_ready stays 0 for the whole cycle after the reset edge(s).
  - out_valid is 0.
  - Inputs are ignored while rst=1.
- State machine (state is encoded by {skid_valid, main_valid}):
  - EMPTY(00): Accept -> main<=in_data, go to ONE.
  - ONE(01):
    - Accept & Drain -> main<=in_data, stay ONE.
    - Accept & ~Drain -> skid<=in_data, go to TWO.
    - ~Accept & Drain -> main_valid<=0, go to EMPTY.
  - TWO(11): in_ready=0, so no accept is possible.
    - Drain -> main<=skid, skid_valid<=0, go to ONE.
    - Otherwise hold.
  - State 10 is illegal and never reached; if it is reached, it recovers to EMPTY on the next edge.
- Latency: a word accepted at edge k appears on out_data at edge k when the buffer was EMPTY, i.e. out_valid is visible one cycle after the handshake.
- Throughput: one word per cycle while out_ready stays 1.
- Order: strict FIFO; a word is never dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold constant.
- in_data is ignored whenever in_ready=0.
- occupancy = main_valid + skid_valid, registered alongside the valid flags.
- Reset mid-operation: held words are discarded, with no drain; this is an identical result to reset from idle.

Optional Feature:
- Macro: PIPE_SKID_FLUSH_EN.
- Defined:
  - Adds port flush, input, 1, placed after rst.
  - flush=1 at an edge clears main_valid, skid_valid and occupancy to 0. Data flops may keep stale values.
  - The Accept and Drain of that same cycle are discarded.
  - in_ready is 1 on the following cycle.
  - rst has priority over flush.
- Undefined:
  - No flush port exists.
  - Only rst clears the buffer.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAAAA -> out_valid=0, occupancy=0, in_ready=0 through the cycle after rst falls, then in_ready=1.
- Streaming: out_ready=1 throughout, send 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 on consecutive cycles, occupancy stays 1, no bubbles.
- Stall and skid: hold out_ready=0, send 0x10 then 0x11 -> occupancy=2, in_ready=0, 0x12 is held off. Raise out_ready -> outputs 0x10, 0x11, 0x12 in order.
- Drain to empty: in ONE with out_data=0x5 and in_valid=0, pulse out_ready -> out_valid=0, occupancy=0 on the next cycle.
- Reset while full: occupancy=2 with 0x20/0x21 held, assert rst for 1 cycle -> out_valid=0, occupancy=0, and 0x20/0x21 never appear.
- Flush (PIPE_SKID_FLUSH_EN defined): occupancy=2, flush=1 with in_valid=1 and in_data=0x30 -> occupancy=0 next cycle, 0x30 is not captured, in_ready=1.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer between pipeline stages: registered in_ready, strict FIFO order.
// Optional synchronous flush port is enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_buffer #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic         flush,
`endif
    input  logic [n-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        ONE     = 2'b01,
        ILLEGAL = 2'b10,
        TWO     = 2'b11
    } state_t;

    logic [n-1:0] r_main_data;
    logic [n-1:0] r_skid_data;
    logic         r_main_valid;
    logic         r_skid_valid;
    logic         r_in_ready;
    logic [1:0]   r_occupancy;

    logic [n-1:0] w_main_data_next;
    logic [n-1:0] w_skid_data_next;
    logic         w_main_valid_next;
    logic         w_skid_valid_next;
    logic         w_in_ready_next;
    logic [1:0]   w_occupancy_next;

    logic         w_accept;
    logic         w_drain;
    logic         w_flush;
    state_t       w_state;

`ifdef PIPE_SKID_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_state  = state_t'({r_skid_valid, r_main_valid});
    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_main_valid & out_ready;

    // State register: the reset edge also forces in_ready low for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_occupancy  <= 2'd0;
        end else begin
            r_main_data  <= w_main_data_next;
            r_skid_data  <= w_skid_data_next;
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= w_in_ready_next;
            r_occupancy  <= w_occupancy_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_main_data_next  = r_main_data;
        w_skid_data_next  = r_skid_data;
        w_main_valid_next = r_main_valid;
        w_skid_valid_next = r_skid_valid;
        case (w_state)
            EMPTY: begin
                if (w_accept) begin
                    w_main_data_next  = in_data;
                    w_main_valid_next = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_main_data_next = in_data;
                end else if (w_accept) begin
                    w_skid_data_next  = in_data;
                    w_skid_valid_next = 1'b1;
                end else if (w_drain) begin
                    w_main_valid_next = 1'b0;
                end
            end
            TWO: begin
                if (w_drain) begin
                    w_main_data_next  = r_skid_data;
                    w_skid_valid_next = 1'b0;
                end
            end
            default: begin
                w_main_valid_next = 1'b0;
                w_skid_valid_next = 1'b0;
            end
        endcase
        // Flush discards this cycle's accept and drain; stale data is harmless.
        if (w_flush) begin
            w_main_valid_next = 1'b0;
            w_skid_valid_next = 1'b0;
        end
        w_in_ready_next  = ~w_skid_valid_next;
        w_occupancy_next = {1'b0, w_main_valid_next} + {1'b0, w_skid_valid_next};
    end

    // Output logic: every output comes straight from a flop.
    always_comb begin
        out_data  = r_main_data;
        out_valid = r_main_valid;
        in_ready  = r_in_ready;
        occupancy = r_occupancy;
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed vector table plus random traffic
// against a queue-based reference model. Define PIPE_SKID_FLUSH_EN to cover flush.
module tb_pipe_skid_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;

    pipe_skid_buffer #(.n(32)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic [31:0] e_data;
    } vec_t;

    vec_t        tbl[$];
    int          n_pass  = 0;
    int          n_total = 0;

    // Reference model: FIFO contents plus the "cycle after reset" flag.
    logic [31:0] mq[$];
    logic        m_rstq  = 1'b1;
    logic        m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add_vec(input logic r, input logic f, input logic iv, input logic [31:0] d,
                           input logic ordy, input logic e_ir, input logic e_ov,
                           input logic [1:0] e_occ, input logic [31:0] e_data);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_data = e_data;
        tbl.push_back(v);
    endtask

    // Drive one cycle: check DUT against the model mid-cycle, then advance the model at the edge.
    task automatic run_cycle(input logic r, input logic f, input logic iv,
                             input logic [31:0] d, input logic ordy);
        logic m_ir;
        logic m_drain;
        logic m_acc;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        m_ir = (mq.size() < 2) && !m_rstq;
        if (m_known) begin
            chk("sb_in_ready", {31'd0, in_ready}, {31'd0, m_ir});
            chk("sb_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            chk("sb_occupancy", {30'd0, occupancy}, mq.size());
            if (mq.size() > 0 && out_valid === 1'b1 && ordy)
                chk("sb_drain_data", out_data, mq[0]);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_rstq  = 1'b1;
            m_known = 1'b1;
        end else begin
            m_rstq = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
            if (f) mq.delete();
            else begin
`else
            begin
`endif
                m_drain = (mq.size() > 0) && ordy;
                m_acc   = iv && m_ir;
                if (m_drain) void'(mq.pop_front());
                if (m_acc) mq.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // rst flush iv data ordy | in_ready out_valid occ out_data (after the edge)
        add_vec(1, 0, 1, 32'hAAAA, 0,   0, 0, 2'd0, 32'h0);
        add_vec(1, 0, 1, 32'hAAAA, 0,   0, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'hAAAA, 0,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'h1,    1,   1, 1, 2'd1, 32'h1);
        add_vec(0, 0, 1, 32'h2,    1,   1, 1, 2'd1, 32'h2);
        add_vec(0, 0, 1, 32'h3,    1,   1, 1, 2'd1, 32'h3);
        add_vec(0, 0, 0, 32'h0,    1,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'h10,   0,   1, 1, 2'd1, 32'h10);
        add_vec(0, 0, 1, 32'h11,   0,   0, 1, 2'd2, 32'h10);
        add_vec(0, 0, 1, 32'h12,   0,   0, 1, 2'd2, 32'h10);
        add_vec(0, 0, 1, 32'h12,   1,   1, 1, 2'd1, 32'h11);
        add_vec(0, 0, 1, 32'h12,   1,   1, 1, 2'd1, 32'h12);
        add_vec(0, 0, 0, 32'h0,    1,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'h5,    0,   1, 1, 2'd1, 32'h5);
        add_vec(0, 0, 0, 32'h0,    0,   1, 1, 2'd1, 32'h5);
        add_vec(0, 0, 0, 32'h0,    1,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'h20,   0,   1, 1, 2'd1, 32'h20);
        add_vec(0, 0, 1, 32'h21,   0,   0, 1, 2'd2, 32'h20);
        add_vec(1, 0, 1, 32'h22,   1,   0, 0, 2'd0, 32'h0);
        add_vec(0, 0, 0, 32'h0,    1,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 0, 32'h0,    1,   1, 0, 2'd0, 32'h0);
`ifdef PIPE_SKID_FLUSH_EN
        add_vec(0, 0, 1, 32'h40,   0,   1, 1, 2'd1, 32'h40);
        add_vec(0, 0, 1, 32'h41,   0,   0, 1, 2'd2, 32'h40);
        add_vec(0, 1, 1, 32'h30,   1,   1, 0, 2'd0, 32'h0);
        add_vec(0, 0, 1, 32'h33,   0,   1, 1, 2'd1, 32'h33);
        add_vec(0, 1, 1, 32'h34,   1,   1, 0, 2'd0, 32'h0);
        add_vec(1, 1, 1, 32'h35,   0,   0, 0, 2'd0, 32'h0);
        add_vec(0, 0, 0, 32'h0,    0,   1, 0, 2'd0, 32'h0);
`endif

        foreach (tbl[i]) begin
            run_cycle(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            $display("vec %0d: rst=%0b flush=%0b iv=%0b d=%0h ordy=%0b -> ir=%0b ov=%0b occ=%0d dout=%0h",
                     i, tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy,
                     in_ready, out_valid, occupancy, out_data);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_ir});
            chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d_occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
            if (tbl[i].e_ov)
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
        end

        // Random traffic with occasional reset (and flush when present), model-checked only.
        for (int k = 0; k < 400; k++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 39) == 0);
`ifdef PIPE_SKID_FLUSH_EN
            f = ($urandom_range(0, 29) == 0);
`else
            f = 1'b0;
`endif
            run_cycle(r, f, 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0));
        end
        run_cycle(0, 0, 0, 32'h0, 1);
        run_cycle(0, 0, 0, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
